sram_axi_rd_arbiter: RTL and testbench

Read-path arbiter that sits inside the SRAM-to-AXI bridge between the two SRAM-like read requesters (instruction fetch and data load) and the single AXI read-address and read-data channels. It accepts at most one request per cycle, holds it on AR until it is accepted, and tags it with a requester ID. It routes R beats back by `rid` and tracks outstanding reads per requester so neither requester exceeds its credit.

---
 rtl/sram_axi_rd_arbiter_pkg.sv | 18 +
 rtl/sram_axi_rd_arbiter_if.sv | 59 +++++
 rtl/sram_axi_rd_arbiter_rd_credit_cnt.sv | 32 +++
 rtl/sram_axi_rd_arbiter.sv | 143 ++++++++++++++
 tb/tb_sram_axi_rd_arbiter.sv | 398 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_axi_rd_arbiter_pkg.sv
// Shared types and constants for the SRAM-to-AXI read-path arbiter.
package sram_axi_rd_arbiter_pkg;

  localparam logic [3:0] RD_ID_INST = 4'd0;
  localparam logic [3:0] RD_ID_DATA = 4'd1;

  localparam logic [7:0] AR_LEN   = 8'd0;
  localparam logic [1:0] AR_BURST = 2'b01;
  localparam logic [1:0] AR_LOCK  = 2'b00;
  localparam logic [3:0] AR_CACHE = 4'b0000;
  localparam logic [2:0] AR_PROT  = 3'b000;

  typedef enum logic {
    IDLE,
    AR_HOLD
  } ar_state_e;

endpackage

// File: rtl/sram_axi_rd_arbiter_if.sv
// Bus bundle for the read arbiter: both SRAM-like requesters plus the AXI AR/R channels.
// Modports are named from the AXI side: master is the arbiter, slave is the surrounding system.
interface sram_axi_rd_arbiter_if;

  logic        inst_rd_req;
  logic [1:0]  inst_rd_size;
  logic [31:0] inst_rd_addr;
  logic        inst_rd_addr_ok;
  logic        inst_rd_data_ok;
  logic [31:0] inst_rd_rdata;

  logic        data_rd_req;
  logic [1:0]  data_rd_size;
  logic [31:0] data_rd_addr;
  logic        data_rd_addr_ok;
  logic        data_rd_data_ok;
  logic [31:0] data_rd_rdata;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    input  inst_rd_req, inst_rd_size, inst_rd_addr,
    output inst_rd_addr_ok, inst_rd_data_ok, inst_rd_rdata,
    input  data_rd_req, data_rd_size, data_rd_addr,
    output data_rd_addr_ok, data_rd_data_ok, data_rd_rdata,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    output inst_rd_req, inst_rd_size, inst_rd_addr,
    input  inst_rd_addr_ok, inst_rd_data_ok, inst_rd_rdata,
    output data_rd_req, data_rd_size, data_rd_addr,
    input  data_rd_addr_ok, data_rd_data_ok, data_rd_rdata,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/sram_axi_rd_arbiter_rd_credit_cnt.sv
// Outstanding-read credit counter for one requester: full at MAX_OUTST, flags a decrement at zero.
module rd_credit_cnt #(
  parameter int MAX_OUTST = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic underflow
);

  localparam int              CNT_W   = $clog2(MAX_OUTST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);

  logic [CNT_W-1:0] cnt;

  assign full      = (cnt == CNT_MAX);
  assign underflow = dec & ~inc & (cnt == '0);

  // A response with nothing outstanding leaves the count pinned at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && !dec) begin
      cnt <= cnt + 1'b1;
    end else if (dec && !inc && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/sram_axi_rd_arbiter.sv
// Read-path arbiter: inst/data requesters onto one AXI AR/R channel pair with per-requester credits.
// Define SRAM_AXI_RD_ARB_RR_EN for round-robin arbitration; default is fixed data-over-inst priority.
module sram_axi_rd_arbiter
  import sram_axi_rd_arbiter_pkg::*;
#(
  parameter int MAX_OUTST = 2
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  sram_axi_rd_arbiter_if.master         bus,
  output logic                          rd_err
);

  ar_state_e   state, next_state;
  logic [31:0] ar_addr_q;
  logic [3:0]  ar_id_q;
  logic [1:0]  ar_size_q;

  logic inst_full, data_full, inst_underflow, data_underflow;
  logic inst_elig, data_elig, pick_data;
  logic grant_inst, grant_data;
  logic r_hs, inst_rsp, data_rsp, rsp_err;

  assign inst_elig = bus.inst_rd_req & ~inst_full;
  assign data_elig = bus.data_rd_req & ~data_full;

`ifdef SRAM_AXI_RD_ARB_RR_EN
  logic last_data_q;

  assign pick_data = data_elig & (~inst_elig | ~last_data_q);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      last_data_q <= 1'b0;
    end else if (grant_inst || grant_data) begin
      last_data_q <= grant_data;
    end
  end
`else
  assign pick_data = data_elig;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Grants are only offered from IDLE, so a held AR blocks every new request until it is taken.
  always_comb begin
    next_state  = state;
    grant_inst  = 1'b0;
    grant_data  = 1'b0;
    bus.arvalid = 1'b0;
    case (state)
      IDLE: begin
        if (aresetn) begin
          grant_data = pick_data;
          grant_inst = inst_elig & ~pick_data;
          if (grant_inst || grant_data) begin
            next_state = AR_HOLD;
          end
        end
      end
      AR_HOLD: begin
        bus.arvalid = 1'b1;
        if (bus.arready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ar_addr_q <= '0;
      ar_id_q   <= RD_ID_INST;
      ar_size_q <= '0;
    end else if (grant_data) begin
      ar_addr_q <= bus.data_rd_addr;
      ar_id_q   <= RD_ID_DATA;
      ar_size_q <= bus.data_rd_size;
    end else if (grant_inst) begin
      ar_addr_q <= bus.inst_rd_addr;
      ar_id_q   <= RD_ID_INST;
      ar_size_q <= bus.inst_rd_size;
    end
  end

  assign bus.inst_rd_addr_ok = grant_inst;
  assign bus.data_rd_addr_ok = grant_data;

  assign bus.arid    = ar_id_q;
  assign bus.araddr  = ar_addr_q;
  assign bus.arsize  = {1'b0, ar_size_q};
  assign bus.arlen   = AR_LEN;
  assign bus.arburst = AR_BURST;
  assign bus.arlock  = AR_LOCK;
  assign bus.arcache = AR_CACHE;
  assign bus.arprot  = AR_PROT;

  // Every read is a single beat, so rlast carries no extra information here.
  assign bus.rready = aresetn;
  assign r_hs       = bus.rvalid & bus.rready;
  assign inst_rsp   = r_hs & (bus.rid == RD_ID_INST);
  assign data_rsp   = r_hs & (bus.rid == RD_ID_DATA);
  assign rsp_err    = r_hs & (((bus.rid != RD_ID_INST) && (bus.rid != RD_ID_DATA)) || (bus.rresp != 2'b00));

  assign bus.inst_rd_data_ok = inst_rsp;
  assign bus.data_rd_data_ok = data_rsp;
  assign bus.inst_rd_rdata   = bus.rdata;
  assign bus.data_rd_rdata   = bus.rdata;

  rd_credit_cnt #(.MAX_OUTST(MAX_OUTST)) u_inst_cnt (
    .clk       (aclk),
    .rst_n     (aresetn),
    .inc       (grant_inst),
    .dec       (inst_rsp),
    .full      (inst_full),
    .underflow (inst_underflow)
  );

  rd_credit_cnt #(.MAX_OUTST(MAX_OUTST)) u_data_cnt (
    .clk       (aclk),
    .rst_n     (aresetn),
    .inc       (grant_data),
    .dec       (data_rsp),
    .full      (data_full),
    .underflow (data_underflow)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_err <= 1'b0;
    end else if (rsp_err || inst_underflow || data_underflow) begin
      rd_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_axi_rd_arbiter.sv
// Scoreboard bench for sram_axi_rd_arbiter: stimulus pushes expectations from a transaction-level model,
// a monitor pops and compares them against what the arbiter presents.
module tb_sram_axi_rd_arbiter;
  import sram_axi_rd_arbiter_pkg::*;

  localparam int MAX_OUTST = 2;

  logic aclk = 1'b0;
  logic aresetn;
  logic rd_err;

  always #5 aclk = ~aclk;

  sram_axi_rd_arbiter_if bus ();

  sram_axi_rd_arbiter #(.MAX_OUTST(MAX_OUTST)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus),
    .rd_err  (rd_err)
  );

  typedef struct {
    logic        req_i;
    logic [1:0]  size_i;
    logic [31:0] addr_i;
    logic        req_d;
    logic [1:0]  size_d;
    logic [31:0] addr_d;
    logic        arready;
    logic        rvalid;
    logic [3:0]  rid;
    logic [1:0]  rresp;
    logic [31:0] rdata;
  } stim_t;

  typedef struct {
    logic        inst_ok;
    logic        data_ok;
    logic        arvalid;
    logic        err;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [2:0]  arsize;
  } cyc_exp_t;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [2:0]  size;
  } ar_exp_t;

  typedef struct {
    int          id;
    logic [31:0] rdata;
  } r_exp_t;

  cyc_exp_t cyc_q[$];
  ar_exp_t  ar_q[$];
  r_exp_t   r_q[$];

  int checks = 0;
  int errors = 0;

  // Transaction-level reference: reads in flight per requester, whether an AR is waiting, sticky error.
  int      m_cnt[2];
  int      m_pend[2];
  bit      m_busy;
  bit      m_last_data;
  bit      m_err;
  ar_exp_t m_held;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic stim_t idleStim();
    stim_t s;
    s.req_i   = 1'b0;
    s.size_i  = 2'd0;
    s.addr_i  = 32'd0;
    s.req_d   = 1'b0;
    s.size_d  = 2'd0;
    s.addr_d  = 32'd0;
    s.arready = 1'b1;
    s.rvalid  = 1'b0;
    s.rid     = 4'd0;
    s.rresp   = 2'd0;
    s.rdata   = 32'd0;
    return s;
  endfunction

  task automatic driveInputs(input stim_t s);
    bus.inst_rd_req  = s.req_i;
    bus.inst_rd_size = s.size_i;
    bus.inst_rd_addr = s.addr_i;
    bus.data_rd_req  = s.req_d;
    bus.data_rd_size = s.size_d;
    bus.data_rd_addr = s.addr_d;
    bus.arready      = s.arready;
    bus.rvalid       = s.rvalid;
    bus.rid          = s.rid;
    bus.rresp        = s.rresp;
    bus.rdata        = s.rdata;
    bus.rlast        = 1'b1;
  endtask

  function automatic void modelReset();
    m_cnt[0]    = 0;
    m_cnt[1]    = 0;
    m_pend[0]   = 0;
    m_pend[1]   = 0;
    m_busy      = 1'b0;
    m_last_data = 1'b0;
    m_err       = 1'b0;
    m_held      = '{4'd0, 32'd0, 3'd0};
    cyc_q.delete();
    ar_q.delete();
    r_q.delete();
  endfunction

  // One clock of stimulus: drive, predict this cycle's outputs, then advance the model past the edge.
  task automatic applyStimulus(input stim_t s);
    bit       ie, de, gi, gd;
    bit       dec[2];
    cyc_exp_t e;
    @(negedge aclk);
    driveInputs(s);
    ie = s.req_i && (m_cnt[0] < MAX_OUTST);
    de = s.req_d && (m_cnt[1] < MAX_OUTST);
    gi = 1'b0;
    gd = 1'b0;
    if (!m_busy) begin
      if (ie && de) begin
`ifdef SRAM_AXI_RD_ARB_RR_EN
        if (m_last_data) gi = 1'b1;
        else             gd = 1'b1;
`else
        gd = 1'b1;
`endif
      end else begin
        gi = ie;
        gd = de;
      end
    end
    e.inst_ok = gi;
    e.data_ok = gd;
    e.arvalid = m_busy;
    e.err     = m_err;
    e.arid    = m_held.id;
    e.araddr  = m_held.addr;
    e.arsize  = m_held.size;
    cyc_q.push_back(e);

    dec[0] = 1'b0;
    dec[1] = 1'b0;
    if (s.rvalid) begin
      if (s.rid == 4'd0 || s.rid == 4'd1) begin
        r_q.push_back('{int'(s.rid), s.rdata});
        dec[s.rid[0]] = 1'b1;
        if (s.rresp != 2'd0) m_err = 1'b1;
      end else begin
        m_err = 1'b1;
      end
    end

    if (gi || gd) begin
      m_held = gd ? '{4'd1, s.addr_d, {1'b0, s.size_d}} : '{4'd0, s.addr_i, {1'b0, s.size_i}};
      ar_q.push_back(m_held);
      m_busy      = 1'b1;
      m_last_data = gd;
    end else if (m_busy && s.arready) begin
      m_busy = 1'b0;
      m_pend[m_held.id[0]]++;
    end

    for (int k = 0; k < 2; k++) begin
      bit inc;
      inc = (k == 0) ? gi : gd;
      if (inc && !dec[k]) begin
        m_cnt[k]++;
      end else if (dec[k] && !inc) begin
        if (m_cnt[k] == 0) m_err = 1'b1;
        else               m_cnt[k]--;
      end
      if (dec[k] && m_pend[k] > 0) m_pend[k]--;
    end
  endtask

  // Asynchronous reset landing mid-cycle; requests and a response are held active to prove gating.
  task automatic doReset();
    stim_t s;
    @(negedge aclk);
    #3;
    s = idleStim();
    s.req_i  = 1'b1;
    s.req_d  = 1'b1;
    s.rvalid = 1'b1;
    s.rid    = 4'd0;
    driveInputs(s);
    aresetn = 1'b0;
    #1;
    checkOutput("rst_arvalid", bus.arvalid, 0);
    checkOutput("rst_araddr", bus.araddr, 0);
    checkOutput("rst_arid", bus.arid, 0);
    checkOutput("rst_arsize", bus.arsize, 0);
    checkOutput("rst_rd_err", rd_err, 0);
    checkOutput("rst_rready", bus.rready, 0);
    checkOutput("rst_inst_addr_ok", bus.inst_rd_addr_ok, 0);
    checkOutput("rst_data_addr_ok", bus.data_rd_addr_ok, 0);
    checkOutput("rst_inst_data_ok", bus.inst_rd_data_ok, 0);
    modelReset();
    repeat (2) @(negedge aclk);
    driveInputs(idleStim());
    aresetn = 1'b1;
  endtask

  task automatic respondAll();
    stim_t s;
    int    guard;
    guard = 0;
    while (m_busy && guard < 20) begin
      applyStimulus(idleStim());
      guard++;
    end
    while ((m_pend[0] + m_pend[1]) > 0 && guard < 40) begin
      s = idleStim();
      s.rvalid = 1'b1;
      s.rid    = (m_pend[0] > 0) ? 4'd0 : 4'd1;
      s.rdata  = $urandom;
      applyStimulus(s);
      guard++;
    end
  endtask

  // Monitor: consumes one expectation per stimulated cycle, plus AR and R transactions as they appear.
  initial begin : monitor
    cyc_exp_t e;
    ar_exp_t  a;
    r_exp_t   r;
    forever begin
      @(negedge aclk);
      #2;
      if (cyc_q.size() > 0) begin
        e = cyc_q.pop_front();
        checkOutput("inst_addr_ok", bus.inst_rd_addr_ok, e.inst_ok);
        checkOutput("data_addr_ok", bus.data_rd_addr_ok, e.data_ok);
        checkOutput("arvalid", bus.arvalid, e.arvalid);
        checkOutput("rd_err", rd_err, e.err);
        checkOutput("rready", bus.rready, 1);
        if (e.arvalid) begin
          checkOutput("hold_araddr", bus.araddr, e.araddr);
          checkOutput("hold_arid", bus.arid, e.arid);
          checkOutput("hold_arsize", bus.arsize, e.arsize);
        end
        if (bus.arvalid && bus.arready) begin
          checkOutput("ar_expected", ar_q.size() > 0, 1);
          if (ar_q.size() > 0) begin
            a = ar_q.pop_front();
            checkOutput("ar_arid", bus.arid, a.id);
            checkOutput("ar_araddr", bus.araddr, a.addr);
            checkOutput("ar_arsize", bus.arsize, a.size);
            checkOutput("ar_arlen", bus.arlen, 0);
            checkOutput("ar_arburst", bus.arburst, 1);
            checkOutput("ar_fixed", {bus.arlock, bus.arcache, bus.arprot}, 0);
          end
        end
        if (bus.inst_rd_data_ok || bus.data_rd_data_ok) begin
          checkOutput("data_ok_onehot", bus.inst_rd_data_ok && bus.data_rd_data_ok, 0);
          checkOutput("r_expected", r_q.size() > 0, 1);
          if (r_q.size() > 0) begin
            r = r_q.pop_front();
            checkOutput("r_route", bus.data_rd_data_ok ? 1 : 0, r.id);
            checkOutput("r_rdata", bus.data_rd_data_ok ? bus.data_rd_rdata : bus.inst_rd_rdata, r.rdata);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin : stimulus
    stim_t s;
    aresetn = 1'b0;
    driveInputs(idleStim());
    modelReset();
    doReset();

    // Single instruction read and its data.
    s = idleStim(); s.req_i = 1'b1; s.addr_i = 32'h1C00_0000; s.size_i = 2'd2;
    applyStimulus(s);
    applyStimulus(idleStim());
    s = idleStim(); s.rvalid = 1'b1; s.rid = 4'd0; s.rdata = 32'hDEAD_BEEF;
    applyStimulus(s);

    // Simultaneous requests; the first winner drops its request once accepted.
    s = idleStim(); s.req_i = 1'b1; s.addr_i = 32'h1000_0004; s.req_d = 1'b1; s.addr_d = 32'h2000_0008; s.size_d = 2'd1;
    applyStimulus(s);
    s.req_d = 1'b0;
    applyStimulus(s);
    applyStimulus(s);
    applyStimulus(idleStim());
    respondAll();

    // Data fills its credits, then retries alongside a returning response.
    s = idleStim(); s.req_d = 1'b1; s.addr_d = 32'h3000_0000;
    applyStimulus(s);
    applyStimulus(idleStim());
    s.addr_d = 32'h3000_0010;
    applyStimulus(s);
    applyStimulus(idleStim());
    s.addr_d = 32'h3000_0020;
    applyStimulus(s);
    s.rvalid = 1'b1; s.rid = 4'd1; s.rdata = 32'h1234_5678;
    applyStimulus(s);
    s.rvalid = 1'b0;
    applyStimulus(s);
    applyStimulus(idleStim());
    respondAll();

    // AR stalled for five cycles with both requesters pressing.
    s = idleStim(); s.req_i = 1'b1; s.addr_i = 32'h4000_0040; s.size_i = 2'd3;
    applyStimulus(s);
    s.req_d = 1'b1; s.addr_d = 32'h5000_0050; s.addr_i = 32'h4000_0080; s.arready = 1'b0;
    repeat (5) applyStimulus(s);
    s.arready = 1'b1;
    applyStimulus(s);
    applyStimulus(s);
    applyStimulus(idleStim());
    respondAll();

    // Randomized traffic with legal responses only.
    for (int i = 0; i < 300; i++) begin
      s = idleStim();
      s.req_i   = 1'($urandom_range(0, 1));
      s.addr_i  = $urandom;
      s.size_i  = 2'($urandom_range(0, 2));
      s.req_d   = 1'($urandom_range(0, 1));
      s.addr_d  = $urandom;
      s.size_d  = 2'($urandom_range(0, 2));
      s.arready = ($urandom_range(0, 3) != 0);
      if ((m_pend[0] + m_pend[1]) > 0 && $urandom_range(0, 1) == 1) begin
        s.rvalid = 1'b1;
        if (m_pend[0] > 0 && m_pend[1] > 0) s.rid = 4'($urandom_range(0, 1));
        else                                s.rid = (m_pend[0] > 0) ? 4'd0 : 4'd1;
        s.rdata = $urandom;
      end
      applyStimulus(s);
    end
    respondAll();

    // Error response still delivers data; a stray rid does not; the flag stays set.
    s = idleStim(); s.req_i = 1'b1; s.addr_i = 32'h6000_0000;
    applyStimulus(s);
    applyStimulus(idleStim());
    s = idleStim(); s.rvalid = 1'b1; s.rid = 4'd0; s.rresp = 2'b10; s.rdata = 32'hBAD0_0001;
    applyStimulus(s);
    s.rresp = 2'b00; s.rid = 4'd3;
    applyStimulus(s);
    repeat (3) applyStimulus(idleStim());

    // Reset while an AR is held, then a response for the dropped read.
    s = idleStim(); s.req_d = 1'b1; s.addr_d = 32'h7000_0000;
    applyStimulus(s);
    s = idleStim(); s.arready = 1'b0;
    applyStimulus(s);
    doReset();
    s = idleStim(); s.rvalid = 1'b1; s.rid = 4'd1; s.rdata = 32'h0BAD_F00D;
    applyStimulus(s);
    repeat (2) applyStimulus(idleStim());
    doReset();

    // Counters start clean after reset: data gets its full credit again.
    s = idleStim(); s.req_d = 1'b1; s.addr_d = 32'h8000_0000;
    repeat (5) applyStimulus(s);
    applyStimulus(idleStim());
    respondAll();
    repeat (2) applyStimulus(idleStim());

    @(negedge aclk);
    #4;
    checkOutput("ar_q_drained", ar_q.size(), 0);
    checkOutput("r_q_drained", r_q.size(), 0);
    checkOutput("cyc_q_drained", cyc_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
